// File: rtl/level_tile_map_if.sv
// Signal bundle joining the level tile map to its level ROM, the gameplay clear port
// and the video lookup path. The map block is the slave; the surrounding system is the master.
interface level_tile_map_if #(
  parameter int ROWS = 30,
  parameter int COLS = 40
);
  logic                      load_start;
  logic [1:0]                level_sel;
  logic [6:0]                rom_addr;
  logic [COLS-1:0]           rom_data;
  logic                      clear_en;
  logic [4:0]                clear_row;
  logic [5:0]                clear_col;
  logic [9:0]                DrawX;
  logic [9:0]                DrawY;
  logic [ROWS-1:0][COLS-1:0] tile;
  logic                      pix_tile;
  logic                      busy;
  logic                      done;

  modport master (
    output load_start, level_sel, rom_data, clear_en, clear_row, clear_col, DrawX, DrawY,
    input  rom_addr, tile, pix_tile, busy, done
  );

  modport slave (
    input  load_start, level_sel, rom_data, clear_en, clear_row, clear_col, DrawX, DrawY,
    output rom_addr, tile, pix_tile, busy, done
  );
endinterface

// File: rtl/level_tile_map.sv
// Collision tile map: streams one level from the synchronous level ROM a row per cycle,
// lets gameplay clear single tiles, and returns a registered tile flag for the pixel being drawn.
module level_tile_map #(
  parameter int ROWS   = 30,
  parameter int COLS   = 40,
  parameter int LEVELS = 4
) (
  input logic Clk,
  input logic Reset,
  level_tile_map_if.slave bus
);
  localparam int         RW         = $clog2(ROWS);
  localparam int         CW         = $clog2(COLS);
  localparam logic [4:0] ROW_LIM    = 5'(ROWS);
  localparam logic [4:0] LAST_ROW   = 5'(ROWS - 1);
  localparam logic [5:0] COL_LIM    = 6'(COLS);
  localparam logic [9:0] X_LIM      = 10'(COLS * 16);
  localparam logic [9:0] Y_LIM      = 10'(ROWS * 16);
  localparam logic [6:0] ROW_STRIDE = 7'(ROWS);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t     state, state_next;
  logic       pending_boot;
  logic [4:0] cnt;
  logic [6:0] base_q;
  logic [6:0] base_new;
  logic [1:0] level_eff;
  logic       start, finish;
  logic       row_we, addr_en, clear_ok, in_view;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      pending_boot <= 1'b1;
      cnt          <= '0;
      base_q       <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        pending_boot <= 1'b0;
        cnt          <= '0;
        base_q       <= base_new;
      end else if (state == LOAD) begin
        cnt <= finish ? 5'd0 : cnt + 5'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (pending_boot || bus.load_start) begin
        start      = 1'b1;
        state_next = LOAD;
      end
      LOAD: if (cnt == ROW_LIM) begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // cnt counts edges inside LOAD; ROM data lags the address by one cycle, so row cnt-1 lands now.
  always_comb begin
    level_eff = '0;
    if (!pending_boot)
      level_eff = (int'(bus.level_sel) >= LEVELS) ? 2'(LEVELS - 1) : bus.level_sel;
    base_new = 7'(level_eff) * ROW_STRIDE;
    row_we   = (state == LOAD) && (cnt != 5'd0);
    addr_en  = (state == LOAD) && (cnt < LAST_ROW);
    clear_ok = (state == IDLE) && !pending_boot && !bus.load_start && bus.clear_en &&
               (bus.clear_row < ROW_LIM) && (bus.clear_col < COL_LIM);
    in_view  = (bus.DrawX < X_LIM) && (bus.DrawY < Y_LIM);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.tile     <= '0;
      bus.rom_addr <= '0;
      bus.pix_tile <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      if (start)
        bus.rom_addr <= base_new;
      else if (addr_en)
        bus.rom_addr <= base_q + 7'(cnt) + 7'd1;
      if (row_we)
        bus.tile[cnt - 5'd1] <= bus.rom_data;
      if (clear_ok)
        bus.tile[bus.clear_row][bus.clear_col] <= 1'b0;
      bus.busy     <= (state_next == LOAD);
      bus.done     <= finish;
      bus.pix_tile <= in_view ? bus.tile[bus.DrawY[RW+3:4]][bus.DrawX[CW+3:4]] : 1'b0;
    end
  end
endmodule

// File: tb/tb_level_tile_map.sv
// Randomised scoreboard bench for level_tile_map: stimulus pushes expectations,
// a negedge monitor pops them when the DUT presents done, a map state or a pixel flag.
module tb_level_tile_map;
  localparam int ROWS   = 30;
  localparam int COLS   = 40;
  localparam int LEVELS = 4;

  typedef logic [ROWS-1:0][COLS-1:0] map_t;
  typedef struct {
    int   kind;
    int   cyc;
    map_t map;
    logic pix;
    logic busy;
    logic done;
  } chk_t;
  typedef struct {
    int   done_cyc;
    int   base;
    map_t map;
  } load_t;

  logic            Clk = 1'b0;
  logic            Reset;
  int              cyc = 0;
  int              total = 0;
  int              bad = 0;
  logic [COLS-1:0] rom [128];
  map_t            model_map;
  chk_t            chk_q[$];
  load_t           load_q[$];
  logic [6:0]      addr_seen[$];

  level_tile_map_if #(.ROWS(ROWS), .COLS(COLS)) bus();

  level_tile_map #(.ROWS(ROWS), .COLS(COLS), .LEVELS(LEVELS)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge Clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  task automatic checkMap(input string name, input map_t got, input map_t want);
    int row_bad;
    row_bad = -1;
    total++;
    if (got !== want) begin
      bad++;
      for (int r = ROWS - 1; r >= 0; r--)
        if (got[r] !== want[r]) row_bad = r;
      $display("[TB] FAIL %s row %0d got=%h want=%h at cycle %0d",
               name, row_bad, got[row_bad], want[row_bad], cyc);
    end
  endtask

  function automatic map_t levelMap(input int lvl);
    map_t m;
    for (int r = 0; r < ROWS; r++) m[r] = rom[lvl * ROWS + r];
    return m;
  endfunction

  always @(negedge Clk) begin : monitor
    load_t e;
    chk_t  c;
    if (Reset === 1'b1)
      addr_seen.delete();
    else if (bus.busy === 1'b1 && addr_seen.size() < ROWS)
      addr_seen.push_back(bus.rom_addr);
    if (bus.done === 1'b1) begin
      if (load_q.size() == 0) begin
        checkOutput("unexpected_done", 64'(load_q.size()), 64'd1);
      end else begin
        e = load_q.pop_front();
        checkOutput("done_cycle", 64'(cyc), 64'(e.done_cyc));
        checkOutput("busy_at_done", 64'(bus.busy), 64'd0);
        checkMap("load_map", bus.tile, e.map);
        checkOutput("rom_addr_count", 64'(addr_seen.size()), 64'(ROWS));
        for (int i = 0; i < addr_seen.size(); i++)
          checkOutput("rom_addr", 64'(addr_seen[i]), 64'(e.base + i));
      end
      addr_seen.delete();
    end
    while (chk_q.size() > 0 && chk_q[0].cyc < cyc) begin
      c = chk_q.pop_front();
      if (c.kind == 0) begin
        checkOutput("pix_tile", 64'(bus.pix_tile), 64'(c.pix));
      end else begin
        checkMap("tile_map", bus.tile, c.map);
        checkOutput("busy", 64'(bus.busy), 64'(c.busy));
        checkOutput("done", 64'(bus.done), 64'(c.done));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pushMap(input int at, input logic busy_exp);
    chk_t c;
    c.kind = 1; c.cyc = at; c.map = model_map; c.pix = 1'b0; c.busy = busy_exp; c.done = 1'b0;
    chk_q.push_back(c);
  endtask

  task automatic pushLoad(input int lvl, input int done_at);
    load_t e;
    e.done_cyc = done_at; e.base = lvl * ROWS; e.map = levelMap(lvl);
    load_q.push_back(e);
    model_map = e.map;
  endtask

  task automatic startLoad(input int lvl);
    bus.level_sel  = 2'(lvl);
    bus.load_start = 1'b1;
    pushLoad(lvl, cyc + 32);
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic releaseReset();
    Reset = 1'b0;
    model_map = '0;
    pushMap(cyc, 1'b1);
    pushLoad(0, cyc + 32);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (load_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (load_q.size() != 0) begin
      checkOutput("load_timeout", 64'(load_q.size()), 64'd0);
      load_q.delete();
    end
    tick();
  endtask

  task automatic doClear(input int r, input int c);
    bus.clear_en  = 1'b1;
    bus.clear_row = 5'(r);
    bus.clear_col = 6'(c);
    if (r < ROWS && c < COLS) model_map[r][c] = 1'b0;
    pushMap(cyc, 1'b0);
    tick();
    bus.clear_en = 1'b0;
  endtask

  task automatic doPixel(input int x, input int y);
    chk_t c;
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    c.kind = 0; c.cyc = cyc; c.map = '0; c.busy = 1'b0; c.done = 1'b0;
    c.pix = (x < COLS * 16 && y < ROWS * 16) ? model_map[y / 16][x / 16] : 1'b0;
    chk_q.push_back(c);
    tick();
  endtask

  task automatic randomPixels(input int n);
    for (int i = 0; i < n; i++) doPixel(int'($urandom_range(700, 0)), int'($urandom_range(540, 0)));
  endtask

  task automatic applyStimulus();
    // Boot load of level 0 straight out of reset.
    tick(); tick();
    model_map = '0;
    pushMap(cyc - 1, 1'b0);
    tick();
    releaseReset();
    waitIdle(60);

    doPixel(120, 50);
    doPixel(640, 50);
    doPixel(100, 40);
    doPixel(639, 479);
    randomPixels(20);

    // Level 2 with a competing start at T10 that must be dropped.
    startLoad(2);
    repeat (9) tick();
    bus.level_sel  = 2'd1;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    waitIdle(60);
    repeat (40) tick();
    pushMap(cyc, 1'b0);
    tick();

    // Full map, with a clear attempted mid-load that must not stick.
    startLoad(1);
    repeat (19) tick();
    bus.clear_en  = 1'b1;
    bus.clear_row = 5'd0;
    bus.clear_col = 6'd0;
    tick();
    bus.clear_en = 1'b0;
    waitIdle(60);

    doClear(5, 39);
    doClear(30, 0);
    doClear(0, 40);
    doClear(31, 63);
    for (int i = 0; i < 12; i++) doClear(int'($urandom_range(31, 0)), int'($urandom_range(63, 0)));
    randomPixels(20);

    for (int k = 0; k < 2; k++) begin
      startLoad(int'($urandom_range(LEVELS - 1, 0)));
      waitIdle(60);
      randomPixels(10);
    end

    // Reset lands at T15 of a level-3 load; the boot load must restart cleanly.
    startLoad(3);
    repeat (14) tick();
    Reset = 1'b1;
    load_q.delete();
    model_map = '0;
    pushMap(cyc - 1, 1'b0);
    tick(); tick();
    releaseReset();
    waitIdle(60);
    randomPixels(5);
    repeat (3) tick();
  endtask

  initial begin
    Reset          = 1'b1;
    bus.load_start = 1'b0;
    bus.level_sel  = 2'd0;
    bus.clear_en   = 1'b0;
    bus.clear_row  = 5'd0;
    bus.clear_col  = 6'd0;
    bus.DrawX      = 10'd0;
    bus.DrawY      = 10'd0;
    for (int a = 0; a < 128; a++) rom[a] = {8'($urandom), 32'($urandom)};
    for (int r = 0; r < ROWS; r++) begin
      rom[r]        = {COLS{r[0]}};
      rom[ROWS + r] = {COLS{1'b1}};
    end
    applyStimulus();
    checkOutput("pending_loads", 64'(load_q.size()), 64'd0);
    checkOutput("pending_checks", 64'(chk_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end
endmodule
